dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_dmem_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
`timescale 1ns/1ps
// dmem_bridge
//   Bridges a simple CPU load/store port onto an internal word-wide data
//   memory. Each access is latched when accepted, held for WAIT_STATES extra
//   cycles, and then completed with a single-cycle cpu_ready pulse. Byte and
//   half accesses use little-endian lanes. Reads are zero- or sign-extended.
//   Accesses that are out of range, misaligned, of illegal size, or that
//   request both read and write complete with cpu_err=1 and leave the memory
//   untouched.
//
//   Optional feature: define DMEM_BRIDGE_ERR_COUNT_EN to build a saturating
//   16-bit count of rejected accesses on err_count. Without it, err_count
//   is tied to 0.
//
// Ports
//   clk_in     in   1   clock, rising edge
//   reset      in   1   synchronous active-high reset
//   cpu_addr   in  32   byte address
//   cpu_wdata  in  32   write data, right-aligned for byte/half
//   cpu_we     in   1   write request
//   cpu_re     in   1   read request
//   cpu_size   in   2   00 word, 01 half, 10 byte, 11 illegal
//   cpu_sign   in   1   sign-extend byte/half reads
//   cpu_rdata  out 32   read data, nonzero only during the ready pulse
//   cpu_ready  out  1   completion pulse
//   cpu_err    out  1   access rejected (qualifies cpu_ready)
//   err_count  out 16   rejected-access count (0 when feature disabled)
//
// FSM states
//   state   | meaning
//   IDLE    | waiting for cpu_we/cpu_re; latches the request on acceptance
//   WAIT    | wait-state down-counter running toward zero
//   DONE    | one-cycle completion: ready/err/rdata driven, write commits
module dmem_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic [15:0] err_count
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam int          WS_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]  WS_LOAD   = WS_LOAD_I[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        re_q;
    logic [1:0]  size_q;
    logic        sign_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   rd_val;
    logic [31:0]   wr_word;
    logic          acc_err;
    logic          in_done;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_we || cpu_re) begin
                    accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WS_LOAD;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture; only meaningful once accepted, so no reset needed.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            we_q    <= cpu_we;
            re_q    <= cpu_re;
            size_q  <= cpu_size;
            sign_q  <= cpu_sign;
        end
    end

    // ------------------------------------------------------------------
    // Address decode and access checks
    // ------------------------------------------------------------------
    assign offset   = addr_q - BASE_ADDR;
    assign word_idx = offset[AW+1:2];
    assign rd_word  = mem[word_idx];

    always_comb begin
        acc_err = 1'b0;
        if (offset >= MEM_BYTES)                       acc_err = 1'b1;
        if (size_q == 2'b11)                           acc_err = 1'b1;
        if (size_q == 2'b01 && offset[0])              acc_err = 1'b1;
        if (size_q == 2'b00 && offset[1:0] != 2'b00)   acc_err = 1'b1;
        if (we_q && re_q)                              acc_err = 1'b1;
    end

    // Reset gates the DONE cycle so an access caught by reset neither pulses
    // ready nor commits its write.
    assign in_done = (state == ST_DONE) && !reset;

    // ------------------------------------------------------------------
    // Read lane selection and extension
    // ------------------------------------------------------------------
    assign rd_byte = rd_word[{offset[1:0], 3'b000} +: 8];
    assign rd_half = offset[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rd_val = 32'd0;
        case (size_q)
            2'b00:   rd_val = rd_word;
            2'b01:   rd_val = {{16{sign_q & rd_half[15]}}, rd_half};
            2'b10:   rd_val = {{24{sign_q & rd_byte[7]}}, rd_byte};
            default: rd_val = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Write lane merge (read-modify-write of the addressed word)
    // ------------------------------------------------------------------
    always_comb begin
        wr_word = rd_word;
        case (size_q)
            2'b00: wr_word = wdata_q;
            2'b01: begin
                if (offset[1]) wr_word[31:16] = wdata_q[15:0];
                else           wr_word[15:0]  = wdata_q[15:0];
            end
            2'b10: wr_word[{offset[1:0], 3'b000} +: 8] = wdata_q[7:0];
            default: wr_word = rd_word;
        endcase
    end

    // Memory is deliberately not reset.
    always_ff @(posedge clk_in) begin
        if (in_done && !acc_err && we_q) begin
            mem[word_idx] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // CPU outputs
    // ------------------------------------------------------------------
    assign cpu_ready = in_done;
    assign cpu_err   = in_done && acc_err;
    assign cpu_rdata = (in_done && !acc_err && re_q) ? rd_val : 32'd0;

`ifdef DMEM_BRIDGE_ERR_COUNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            err_cnt_q <= 16'd0;
        end else if (in_done && acc_err && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
`timescale 1ns/1ps
module tb_dmem_bridge;

`ifdef DMEM_BRIDGE_ERR_COUNT_EN
    localparam int EC_EN = 1;
`else
    localparam int EC_EN = 0;
`endif

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    // DUT with one wait state
    logic [31:0] a1 = '0, wd1 = '0, rd1;
    logic        we1 = 1'b0, re1 = 1'b0, sg1 = 1'b0, rdy1, err1;
    logic [1:0]  sz1 = 2'b00;
    logic [15:0] ec1;

    // DUT with zero wait states
    logic [31:0] a0 = '0, wd0 = '0, rd0;
    logic        we0 = 1'b0, re0 = 1'b0, sg0 = 1'b0, rdy0, err0;
    logic [1:0]  sz0 = 2'b00;
    logic [15:0] ec0;

    dmem_bridge #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
        .clk_in(clk_in), .reset(reset), .cpu_addr(a1), .cpu_wdata(wd1),
        .cpu_we(we1), .cpu_re(re1), .cpu_size(sz1), .cpu_sign(sg1),
        .cpu_rdata(rd1), .cpu_ready(rdy1), .cpu_err(err1), .err_count(ec1));

    dmem_bridge #(.BASE_ADDR(32'h1001_0000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk_in(clk_in), .reset(reset), .cpu_addr(a0), .cpu_wdata(wd0),
        .cpu_we(we0), .cpu_re(re0), .cpu_size(sz0), .cpu_sign(sg0),
        .cpu_rdata(rd0), .cpu_ready(rdy0), .cpu_err(err0), .err_count(ec0));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the WAIT_STATES=1 DUT; returns data/err at the ready
    // pulse and the number of cycles from acceptance to that pulse.
    task automatic acc1(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                        output logic [31:0] rdata, output logic e, output int lat);
        @(negedge clk_in);
        we1 = we; re1 = re; a1 = a; wd1 = wd; sz1 = sz; sg1 = sg;
        @(posedge clk_in);
        #1;
        we1 = 1'b0; re1 = 1'b0;
        lat   = 99;
        rdata = 32'hxxxx_xxxx;
        e     = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            if (rdy1) begin
                lat   = k;
                rdata = rd1;
                e     = err1;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        seen;

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("rst_ready", {31'd0, rdy1}, 32'd0);
        chk("rst_err",   {31'd0, err1}, 32'd0);
        chk("rst_rdata", rd1, 32'd0);
        chk("rst_errcnt", {16'd0, ec1}, 32'd0);
        reset = 1'b0;

        // Word write then word read
        acc1(1, 0, 32'h1001_0010, 32'hDEAD_BEEF, 2'b00, 0, d, e, lat);
        chk("ww_lat", lat, 2);
        chk("ww_err", {31'd0, e}, 32'd0);
        chk("ww_rdata", d, 32'd0);
        acc1(0, 1, 32'h1001_0010, 32'h0, 2'b00, 0, d, e, lat);
        chk("wr_lat", lat, 2);
        chk("wr_err", {31'd0, e}, 32'd0);
        chk("wr_data", d, 32'hDEAD_BEEF);

        // Byte lane write and extended reads
        acc1(1, 0, 32'h1001_0013, 32'h0000_0080, 2'b10, 0, d, e, lat);
        chk("bw_err", {31'd0, e}, 32'd0);
        acc1(0, 1, 32'h1001_0013, 32'h0, 2'b10, 1, d, e, lat);
        chk("br_signed", d, 32'hFFFF_FF80);
        acc1(0, 1, 32'h1001_0013, 32'h0, 2'b10, 0, d, e, lat);
        chk("br_unsigned", d, 32'h0000_0080);
        acc1(0, 1, 32'h1001_0010, 32'h0, 2'b00, 1, d, e, lat);
        chk("after_bw_word", d, 32'h80AD_BEEF);
        acc1(0, 1, 32'h1001_0012, 32'h0, 2'b01, 1, d, e, lat);
        chk("hr_hi_signed", d, 32'hFFFF_80AD);
        acc1(0, 1, 32'h1001_0010, 32'h0, 2'b01, 1, d, e, lat);
        chk("hr_lo_signed", d, 32'hFFFF_BEEF);

        // Half write to the low lane
        acc1(1, 0, 32'h1001_0010, 32'h0000_1234, 2'b01, 0, d, e, lat);
        acc1(0, 1, 32'h1001_0010, 32'h0, 2'b00, 0, d, e, lat);
        chk("hw_word", d, 32'h80AD_1234);

        // Rejected accesses: misaligned half, out-of-range word write
        acc1(0, 1, 32'h1001_0011, 32'h0, 2'b01, 0, d, e, lat);
        chk("mis_half_lat", lat, 2);
        chk("mis_half_err", {31'd0, e}, 32'd1);
        chk("mis_half_rdata", d, 32'd0);
        acc1(1, 0, 32'h1001_1000, 32'h5555_AAAA, 2'b00, 0, d, e, lat);
        chk("oor_err", {31'd0, e}, 32'd1);
        chk("oor_rdata", d, 32'd0);
        @(negedge clk_in);
        chk("errcnt_2", {16'd0, ec1}, 32'(2 * EC_EN));
        acc1(0, 1, 32'h1001_0010, 32'h0, 2'b00, 0, d, e, lat);
        chk("mem_kept_1", d, 32'h80AD_1234);

        // Last valid word boundary
        acc1(1, 0, 32'h1001_0FFC, 32'hCAFE_F00D, 2'b00, 0, d, e, lat);
        chk("last_w_err", {31'd0, e}, 32'd0);
        acc1(0, 1, 32'h1001_0FFC, 32'h0, 2'b00, 0, d, e, lat);
        chk("last_r_data", d, 32'hCAFE_F00D);
        chk("last_r_err", {31'd0, e}, 32'd0);

        // Simultaneous we and re at a valid address
        acc1(1, 1, 32'h1001_0010, 32'h0000_0000, 2'b00, 0, d, e, lat);
        chk("wer_err", {31'd0, e}, 32'd1);
        chk("wer_rdata", d, 32'd0);
        acc1(0, 1, 32'h1001_0010, 32'h0, 2'b00, 0, d, e, lat);
        chk("mem_kept_2", d, 32'h80AD_1234);
        chk("errcnt_3", {16'd0, ec1}, 32'(3 * EC_EN));

        // Reset during WAIT aborts the write
        acc1(1, 0, 32'h1001_0020, 32'h1234_5678, 2'b00, 0, d, e, lat);
        @(negedge clk_in);
        we1 = 1'b1; a1 = 32'h1001_0020; wd1 = 32'hAAAA_5555; sz1 = 2'b00;
        @(posedge clk_in);
        #1;
        we1 = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;
        #1;
        chk("abort_rdy_in_rst", {31'd0, rdy1}, 32'd0);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            seen = seen | rdy1;
        end
        chk("abort_no_ready", {31'd0, seen}, 32'd0);
        chk("abort_errcnt", {16'd0, ec1}, 32'd0);
        acc1(0, 1, 32'h1001_0020, 32'h0, 2'b00, 0, d, e, lat);
        chk("abort_mem_prior", d, 32'h1234_5678);

        // Zero wait states: write, then back-to-back reads held high
        @(negedge clk_in);
        we0 = 1'b1; a0 = 32'h1001_0000; wd0 = 32'h1122_3344; sz0 = 2'b00;
        @(posedge clk_in);
        #1;
        we0 = 1'b0;
        @(negedge clk_in);
        chk("ws0_w_ready", {31'd0, rdy0}, 32'd1);
        chk("ws0_w_err", {31'd0, err0}, 32'd0);
        @(negedge clk_in);
        re0 = 1'b1; sg0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            chk($sformatf("ws0_rdy_%0d", k), {31'd0, rdy0}, ((k % 2) == 0) ? 32'd1 : 32'd0);
            if ((k % 2) == 0) chk($sformatf("ws0_data_%0d", k), rd0, 32'h1122_3344);
        end
        re0 = 1'b0;
        repeat (2) @(negedge clk_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
